video_mixer: RTL and testbench

Generates 640x480@60 raster timing for the video pipeline and composites the tile and sprite layers into the final VGA pixel. Drives `row`, `col` and `vblank` to the sprite and tile datapaths, which use vblank to fetch sprite attributes. Consumes their per-pixel colour after a fixed latency. Delays sync and blanking to match that latency, so the `vga_*` outputs are pixel-aligned.

---
 rtl/video_pkg.sv | 35 +++
 rtl/video_mixer_if.sv | 33 +++
 rtl/vga_timing.sv | 60 ++++++
 rtl/video_mixer.sv | 117 +++++++++++
 tb/tb_video_mixer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared raster timing defaults and pixel colour types for the video pipeline.
package video_pkg;

  localparam int H_VISIBLE    = 640;
  localparam int H_TOTAL      = 800;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 752;
  localparam int V_VISIBLE    = 480;
  localparam int V_TOTAL      = 525;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 492;
  localparam int PIPE_LAT     = 2;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t RGB_TRANSPARENT = '{r: 4'h0, g: 4'h0, b: 4'h0};

  // One tap of the sync/blank delay line.
  typedef struct packed {
    logic active;
    logic hsync_n;
    logic vsync_n;
  } sync_tap_t;

  localparam sync_tap_t SYNC_TAP_IDLE = '{active: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};

  function automatic logic is_opaque(input rgb_t c);
    return c != RGB_TRANSPARENT;
  endfunction

endpackage

// File: rtl/video_mixer_if.sv
// Raster position out to the layer datapaths, layer colours back in, VGA pixel out.
interface video_mixer_if;

  logic [8:0] row;
  logic [9:0] col;
  logic       vblank;
  logic       hblank;
  logic       frame_start;
  logic [3:0] tile_r;
  logic [3:0] tile_g;
  logic [3:0] tile_b;
  logic [3:0] sprite_r;
  logic [3:0] sprite_g;
  logic [3:0] sprite_b;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic       vga_hsync_n;
  logic       vga_vsync_n;

  modport master (
    output row, col, vblank, hblank, frame_start,
    input  tile_r, tile_g, tile_b, sprite_r, sprite_g, sprite_b,
    output vga_r, vga_g, vga_b, vga_hsync_n, vga_vsync_n
  );

  modport slave (
    input  row, col, vblank, hblank, frame_start,
    output tile_r, tile_g, tile_b, sprite_r, sprite_g, sprite_b,
    input  vga_r, vga_g, vga_b, vga_hsync_n, vga_vsync_n
  );

endinterface

// File: rtl/vga_timing.sv
// Free-running h/v raster counters with registered position, blanking, sync and frame pulse.
module vga_timing
  import video_pkg::*;
#(
  parameter int H_VISIBLE    = video_pkg::H_VISIBLE,
  parameter int H_TOTAL      = video_pkg::H_TOTAL,
  parameter int H_SYNC_START = video_pkg::H_SYNC_START,
  parameter int H_SYNC_END   = video_pkg::H_SYNC_END,
  parameter int V_VISIBLE    = video_pkg::V_VISIBLE,
  parameter int V_TOTAL      = video_pkg::V_TOTAL,
  parameter int V_SYNC_START = video_pkg::V_SYNC_START,
  parameter int V_SYNC_END   = video_pkg::V_SYNC_END
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [8:0] row,
  output logic [9:0] col,
  output logic       vblank,
  output logic       hblank,
  output logic       frame_start,
  output logic       hsync_n,
  output logic       vsync_n
);

  logic [9:0] hcount_reg;
  logic [9:0] vcount_reg;
  logic       h_wrap;
  logic       v_wrap;

  assign h_wrap = (hcount_reg == 10'(H_TOTAL - 1));
  assign v_wrap = (vcount_reg == 10'(V_TOTAL - 1));

  // Outputs describe the counter values of the current cycle, so they trail the counters by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_reg  <= '0;
      vcount_reg  <= '0;
      row         <= '0;
      col         <= '0;
      vblank      <= 1'b0;
      hblank      <= 1'b0;
      frame_start <= 1'b0;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
    end else begin
      hcount_reg <= h_wrap ? '0 : hcount_reg + 10'd1;
      if (h_wrap) begin
        vcount_reg <= v_wrap ? '0 : vcount_reg + 10'd1;
      end
      col         <= hcount_reg;
      row         <= (vcount_reg < 10'(V_VISIBLE)) ? vcount_reg[8:0] : '0;
      vblank      <= (vcount_reg >= 10'(V_VISIBLE));
      hblank      <= (hcount_reg >= 10'(H_VISIBLE));
      frame_start <= (hcount_reg == '0) && (vcount_reg == '0);
      hsync_n     <= !((hcount_reg >= 10'(H_SYNC_START)) && (hcount_reg < 10'(H_SYNC_END)));
      vsync_n     <= !((vcount_reg >= 10'(V_SYNC_START)) && (vcount_reg < 10'(V_SYNC_END)));
    end
  end

endmodule

// File: rtl/video_mixer.sv
// Raster timing plus latency-matched compositing of sprite over tile into the VGA pixel.
module video_mixer
  import video_pkg::*;
#(
  parameter int H_VISIBLE    = video_pkg::H_VISIBLE,
  parameter int H_TOTAL      = video_pkg::H_TOTAL,
  parameter int H_SYNC_START = video_pkg::H_SYNC_START,
  parameter int H_SYNC_END   = video_pkg::H_SYNC_END,
  parameter int V_VISIBLE    = video_pkg::V_VISIBLE,
  parameter int V_TOTAL      = video_pkg::V_TOTAL,
  parameter int V_SYNC_START = video_pkg::V_SYNC_START,
  parameter int V_SYNC_END   = video_pkg::V_SYNC_END,
  parameter int PIPE_LAT     = video_pkg::PIPE_LAT
) (
  input  logic          clk,
  input  logic          rst_n,
  video_mixer_if.master bus
);

  logic [8:0] row;
  logic [9:0] col;
  logic       vblank;
  logic       hblank;
  logic       frame_start;
  logic       hsync_n;
  logic       vsync_n;
  logic       run_reg;
  sync_tap_t  tap_in;
  sync_tap_t  mix_tap;
  sync_tap_t  out_tap;
  rgb_t       sprite_c;
  rgb_t       tile_c;
  rgb_t       mix_next;
  rgb_t       vga_reg;

  vga_timing #(
    .H_VISIBLE    (H_VISIBLE),
    .H_TOTAL      (H_TOTAL),
    .H_SYNC_START (H_SYNC_START),
    .H_SYNC_END   (H_SYNC_END),
    .V_VISIBLE    (V_VISIBLE),
    .V_TOTAL      (V_TOTAL),
    .V_SYNC_START (V_SYNC_START),
    .V_SYNC_END   (V_SYNC_END)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .row         (row),
    .col         (col),
    .vblank      (vblank),
    .hblank      (hblank),
    .frame_start (frame_start),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n)
  );

  // The timing outputs hold reset values for the cycle before the first real pixel; keep that out of the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
    end
  end

  assign tap_in = '{active: run_reg && !hblank && !vblank, hsync_n: hsync_n, vsync_n: vsync_n};

  for (genvar gi = 0; gi <= PIPE_LAT; gi++) begin : g_dly
    sync_tap_t tap_reg;
    sync_tap_t tap_prev;
    if (gi == 0) begin : g_head
      assign tap_prev = tap_in;
    end else begin : g_link
      assign tap_prev = g_dly[gi-1].tap_reg;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tap_reg <= SYNC_TAP_IDLE;
      end else begin
        tap_reg <= tap_prev;
      end
    end
  end

  // Mixing consumes the tap one stage early so the colour register lands in step with the syncs.
  assign mix_tap  = g_dly[PIPE_LAT-1].tap_reg;
  assign out_tap  = g_dly[PIPE_LAT].tap_reg;
  assign sprite_c = '{r: bus.sprite_r, g: bus.sprite_g, b: bus.sprite_b};
  assign tile_c   = '{r: bus.tile_r, g: bus.tile_g, b: bus.tile_b};

  always_comb begin
    mix_next = RGB_TRANSPARENT;
    if (mix_tap.active) begin
      mix_next = is_opaque(sprite_c) ? sprite_c : tile_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_reg <= RGB_TRANSPARENT;
    end else begin
      vga_reg <= mix_next;
    end
  end

  assign bus.row         = row;
  assign bus.col         = col;
  assign bus.vblank      = vblank;
  assign bus.hblank      = hblank;
  assign bus.frame_start = frame_start;
  assign bus.vga_r       = vga_reg.r;
  assign bus.vga_g       = vga_reg.g;
  assign bus.vga_b       = vga_reg.b;
  assign bus.vga_hsync_n = out_tap.hsync_n;
  assign bus.vga_vsync_n = out_tap.vsync_n;

endmodule

// File: tb/tb_video_mixer.sv
// Drives random layer colours into four mixers (shrunk and full raster, latency 1/2/4) and checks them against a raster model.
module tb_video_mixer;

  localparam int NCFG = 4;
  localparam int LAT_C [NCFG] = '{2, 1, 4, 2};
  localparam int HV_C  [NCFG] = '{40, 40, 40, 640};
  localparam int HT_C  [NCFG] = '{50, 50, 50, 800};
  localparam int HSS_C [NCFG] = '{42, 42, 42, 656};
  localparam int HSE_C [NCFG] = '{46, 46, 46, 752};
  localparam int VV_C  [NCFG] = '{6, 6, 6, 480};
  localparam int VT_C  [NCFG] = '{10, 10, 10, 525};
  localparam int VSS_C [NCFG] = '{7, 7, 7, 490};
  localparam int VSE_C [NCFG] = '{9, 9, 9, 492};

  logic        clk;
  logic        rst_n;
  logic [11:0] tile_drv;
  logic [11:0] sprite_drv;
  logic [11:0] tile_hist [2048];
  logic [11:0] spr_hist  [2048];
  int          n_vec;
  int          n_err;

  logic [NCFG-1:0][8:0]  o_row;
  logic [NCFG-1:0][9:0]  o_col;
  logic [NCFG-1:0][11:0] o_rgb;
  logic [NCFG-1:0]       o_vb;
  logic [NCFG-1:0]       o_hb;
  logic [NCFG-1:0]       o_fs;
  logic [NCFG-1:0]       o_hs;
  logic [NCFG-1:0]       o_vs;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
    video_mixer_if bus ();
    assign bus.tile_r   = tile_drv[11:8];
    assign bus.tile_g   = tile_drv[7:4];
    assign bus.tile_b   = tile_drv[3:0];
    assign bus.sprite_r = sprite_drv[11:8];
    assign bus.sprite_g = sprite_drv[7:4];
    assign bus.sprite_b = sprite_drv[3:0];
    video_mixer #(
      .H_VISIBLE    (HV_C[gi]),
      .H_TOTAL      (HT_C[gi]),
      .H_SYNC_START (HSS_C[gi]),
      .H_SYNC_END   (HSE_C[gi]),
      .V_VISIBLE    (VV_C[gi]),
      .V_TOTAL      (VT_C[gi]),
      .V_SYNC_START (VSS_C[gi]),
      .V_SYNC_END   (VSE_C[gi]),
      .PIPE_LAT     (LAT_C[gi])
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
    );
    assign o_row[gi] = bus.row;
    assign o_col[gi] = bus.col;
    assign o_vb[gi]  = bus.vblank;
    assign o_hb[gi]  = bus.hblank;
    assign o_fs[gi]  = bus.frame_start;
    assign o_hs[gi]  = bus.vga_hsync_n;
    assign o_vs[gi]  = bus.vga_vsync_n;
    assign o_rgb[gi] = {bus.vga_r, bus.vga_g, bus.vga_b};
  end

  task automatic check(input string tag, input int k, input int n,
                       input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d cycle %0d observed=%0h expected=%0h", tag, k, n, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    for (int k = 0; k < NCFG; k++) begin
      check({tag, "_row"}, k, -1, 32'(o_row[k]), 32'd0);
      check({tag, "_col"}, k, -1, 32'(o_col[k]), 32'd0);
      check({tag, "_vblank"}, k, -1, 32'(o_vb[k]), 32'd0);
      check({tag, "_hblank"}, k, -1, 32'(o_hb[k]), 32'd0);
      check({tag, "_frame_start"}, k, -1, 32'(o_fs[k]), 32'd0);
      check({tag, "_rgb"}, k, -1, 32'(o_rgb[k]), 32'd0);
      check({tag, "_hsync"}, k, -1, 32'(o_hs[k]), 32'd1);
      check({tag, "_vsync"}, k, -1, 32'(o_vs[k]), 32'd1);
    end
  endtask

  // Reference: cycle n after release shows raster position n; the VGA pins show pixel n-LAT-1 with colour driven at n-1.
  task automatic check_cycle(input int k, input int n);
    int ht, vt, lat, h, v, p, hp, vp;
    logic [11:0] exp_rgb;
    logic exp_hs, exp_vs, act;
    ht  = HT_C[k];
    vt  = VT_C[k];
    lat = LAT_C[k];
    h   = n % ht;
    v   = (n / ht) % vt;
    check("col", k, n, 32'(o_col[k]), h);
    check("row", k, n, 32'(o_row[k]), (v < VV_C[k]) ? v : 0);
    check("vblank", k, n, 32'(o_vb[k]), 32'(v >= VV_C[k]));
    check("hblank", k, n, 32'(o_hb[k]), 32'(h >= HV_C[k]));
    check("frame_start", k, n, 32'(o_fs[k]), 32'(h == 0 && v == 0));
    exp_rgb = 12'h000;
    exp_hs  = 1'b1;
    exp_vs  = 1'b1;
    if (n >= lat + 1) begin
      p   = n - lat - 1;
      hp  = p % ht;
      vp  = (p / ht) % vt;
      act = (hp < HV_C[k]) && (vp < VV_C[k]);
      exp_hs = !(hp >= HSS_C[k] && hp < HSE_C[k]);
      exp_vs = !(vp >= VSS_C[k] && vp < VSE_C[k]);
      if (act) begin
        exp_rgb = (spr_hist[n-1] != 12'h000) ? spr_hist[n-1] : tile_hist[n-1];
      end
    end
    check("vga_rgb", k, n, 32'(o_rgb[k]), 32'(exp_rgb));
    check("vga_hsync_n", k, n, 32'(o_hs[k]), 32'(exp_hs));
    check("vga_vsync_n", k, n, 32'(o_vs[k]), 32'(exp_vs));
  endtask

  task automatic drive(input int n, input bit hold_white);
    logic [11:0] t, s;
    t = 12'($urandom);
    s = ($urandom_range(0, 1) == 0) ? 12'h000 : 12'($urandom);
    if (hold_white) begin
      s = 12'hFFF;
    end else if (n == 12) begin
      t = 12'hABC;
      s = 12'h000;
    end else if (n == 62) begin
      s = 12'h00F;
    end
    tile_drv     = t;
    sprite_drv   = s;
    tile_hist[n] = t;
    spr_hist[n]  = s;
  endtask

  task automatic run(input int ncyc, input bit hold_white);
    int hs_run, vs_run, last_fs;
    hs_run  = 0;
    vs_run  = 0;
    last_fs = -1;
    for (int n = 0; n < ncyc; n++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NCFG; k++) check_cycle(k, n);
      if (!hold_white && n == 13) check("transparent_tile", 0, n, 32'(o_rgb[0]), 32'h0ABC);
      if (!hold_white && n == 63) check("opaque_sprite", 0, n, 32'(o_rgb[0]), 32'h000F);
      if (o_hs[3] == 1'b0) begin
        hs_run++;
      end else if (hs_run > 0) begin
        check("hsync_width", 3, n, hs_run, 96);
        hs_run = 0;
      end
      if (o_vs[0] == 1'b0) begin
        vs_run++;
      end else if (vs_run > 0) begin
        check("vsync_width", 0, n, vs_run, 2 * 50);
        vs_run = 0;
      end
      if (o_fs[0]) begin
        if (last_fs >= 0) check("frame_period", 0, n, n - last_fs, 50 * 10);
        last_fs = n;
      end
      drive(n, hold_white);
    end
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    tile_drv   = 12'h000;
    sprite_drv = 12'hFFF;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");

    // Opaque white sprite throughout: anything visible outside the active window is a blanking leak.
    @(negedge clk);
    rst_n = 1'b1;
    run(300, 1'b1);

    // Cycle 300: full-raster mixer sits at col 300; reset lands mid-line with no clock edge.
    @(posedge clk);
    #1;
    for (int k = 0; k < NCFG; k++) check_cycle(k, 300);
    check("midline_col", 3, 300, 32'(o_col[3]), 32'd300);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async");
    repeat (3) @(posedge clk);
    #1;
    check_reset("held");

    @(negedge clk);
    rst_n = 1'b1;
    run(1400, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
